data_mem_controller: RTL and testbench
======================================

# data_mem_controller

Initiator-side sequencer for the 16 × 8 data memory. It accepts single load/store and block fill/copy requests from the core over a valid/ready handshake. It drives the memory's enable, write-enable, address and write-data pins, and captures read data. It sits between the datapath's load/store path and the data memory, and is the only block that drives the memory interface.

## Interface
- AW, 4, address width; memory depth is 2^AW, and every address wraps mod 2^AW.
- DW, 8, data width.

- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  high in IDLE only; a request is accepted on an edge where req_valid && req_ready.
- req_op  in  2  00 LOAD, 01 STORE, 10 COPY, 11 FILL.
- req_addr  in  AW  target address: LOAD/STORE location, or destination start for FILL/COPY.
- req_src  in  AW  COPY source start; ignored by other ops.
- req_len  in  AW  FILL/COPY byte count minus 1, giving 1..16 bytes; ignored by LOAD/STORE.
- req_wdata  in  DW  STORE data and FILL pattern.
- busy  out  1  state != IDLE.
- done  out  1  one-cycle pulse when an accepted request completes.
- rdata  out  DW  last LOAD result; held until the next LOAD completes.
- mem_E  out  1  memory enable.
- mem_WE  out  1  memory write enable.
- mem_Addr  out  AW  memory address.
- mem_Data_in  out  DW  memory write data.
- mem_Data_out  in  DW  memory read data, combinational from mem_Addr while mem_E && !mem_WE.

## Operation
- FSM states: IDLE, RD, WR, DONE.
- On accept, register op, addr, src, cnt = len, and wdata; request inputs are ignored afterwards until IDLE.
- mem_* outputs are decoded from state and internal registers only; there is no combinational path from request inputs.
- RD drives mem_E=1, mem_WE=0, mem_Addr = current read address, and captures mem_Data_out on the closing edge.
- WR drives mem_E=1, mem_WE=1, mem_Addr = current write address, mem_Data_in = write data; the memory commits on the closing edge.
- IDLE and DONE drive all mem_* outputs to 0.
- LOAD: IDLE→RD→DONE→IDLE; the RD capture goes into rdata.
- STORE: IDLE→WR→DONE→IDLE; write data is the registered wdata.
- FILL: IDLE→WR repeated len+1 times, writing wdata. The address increments mod 2^AW after each WR. When cnt==0 the next state is DONE; otherwise decrement cnt.
- COPY: IDLE→(RD→WR) repeated len+1 times.
  - RD reads src into an internal byte buffer, and WR writes the buffer to the destination address.
  - src and dst both increment mod 2^AW after each WR.
  - Processing is strictly ascending, so overlapping ranges propagate (see test 4).
  - COPY never updates rdata.
- DONE lasts exactly one cycle with done=1, then returns to IDLE.

## Timing
- Reset values: state IDLE, req_ready=1, busy=0, done=0, rdata=0, mem_E=0, mem_WE=0, mem_Addr=0, mem_Data_in=0, internal registers 0.
- Accept edge is t0. Latencies measured from t0:
  - LOAD: RD in cycle 1, done and new rdata in cycle 2, req_ready in cycle 3.
  - STORE: write commits at end of cycle 1, done in cycle 2.
  - FILL n bytes: WR in cycles 1..n, done in cycle n+1.
  - COPY n bytes: cycles 1..2n, done in cycle 2n+1.
- No back-to-back accept: at least one IDLE cycle between requests.
- Address wrap: address 15 + 1 gives 0. A length-16 FILL/COPY touches every location once.
- Reset mid-operation:
  - State goes to IDLE and mem_E drops immediately, so the pending write at the next edge is suppressed.
  - Bytes already committed remain; no done pulse is generated; rdata is reset to 0.
- req_valid while busy has no effect, and the request is not queued.

## Test plan
- STORE addr=3, wdata=0xA5, then LOAD addr=3 → mem_E/WE=1/1 at Addr 3 in cycle 1; done in cycle 2; the LOAD then returns rdata=0xA5 with done two cycles after its accept.
- FILL addr=14, len=3, wdata=0x5C → writes to addresses 14, 15, 0, 1 in consecutive cycles; done in cycle 5; LOADs from those addresses return 0x5C, and address 2 is unchanged.
- COPY src=4, dst=8, len=1, with mem[4]=0x11, mem[5]=0x22 → RD4, WR8, RD5, WR9; done in cycle 5; mem[8]=0x11, mem[9]=0x22; rdata unchanged.
- Overlapping COPY src=0, dst=1, len=2, with mem[0..3]=0xA,0xB,0xC,0xD → mem[0..3]=0xA,0xA,0xA,0xA.
- FILL addr=0, len=7, wdata=0xFF, with rst pulsed after 3 WR cycles → mem[0..2]=0xFF, mem[3..7] unchanged; no done pulse; mem_E=0 and req_ready=1 immediately.
- req_valid held high with a second STORE during a FILL → second request ignored until IDLE; then accepted with exactly one IDLE gap, and one done pulse per accepted request.

Source files
------------

// File: rtl/data_mem_controller.sv
// Initiator-side sequencer for the 16x8 data memory: single LOAD/STORE and
// block FILL/COPY requests taken over valid/ready and driven onto the memory pins.
module data_mem_controller #(
  parameter int unsigned AW = 4,
  parameter int unsigned DW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic [1:0]    req_op,
  input  logic [AW-1:0] req_addr,
  input  logic [AW-1:0] req_src,
  input  logic [AW-1:0] req_len,
  input  logic [DW-1:0] req_wdata,
  output logic          busy,
  output logic          done,
  output logic [DW-1:0] rdata,
  output logic          mem_E,
  output logic          mem_WE,
  output logic [AW-1:0] mem_Addr,
  output logic [DW-1:0] mem_Data_in,
  input  logic [DW-1:0] mem_Data_out
);

  localparam logic [1:0] OP_LOAD  = 2'b00;
  localparam logic [1:0] OP_STORE = 2'b01;
  localparam logic [1:0] OP_COPY  = 2'b10;
  localparam logic [1:0] OP_FILL  = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RD   = 2'b01,
    WR   = 2'b10,
    DONE = 2'b11
  } state_t;

  state_t        state, state_n;
  logic [1:0]    op_q;
  logic [AW-1:0] addr_q;
  logic [AW-1:0] src_q;
  logic [AW-1:0] cnt_q;
  logic [DW-1:0] wdata_q;
  logic [DW-1:0] buf_q;
  logic [DW-1:0] rdata_q;
  logic          accept;

  assign accept = (state == IDLE) && req_valid;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE: begin
        if (req_valid) begin
          if (req_op == OP_LOAD || req_op == OP_COPY) state_n = RD;
          else                                        state_n = WR;
        end
      end
      RD:   state_n = (op_q == OP_LOAD) ? DONE : WR;
      WR: begin
        if (op_q == OP_STORE || cnt_q == '0) state_n = DONE;
        else if (op_q == OP_COPY)            state_n = RD;
        else                                 state_n = WR;
      end
      DONE: state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Request capture, read-data capture and block-transfer address/count stepping.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_q    <= OP_LOAD;
      addr_q  <= '0;
      src_q   <= '0;
      cnt_q   <= '0;
      wdata_q <= '0;
      buf_q   <= '0;
      rdata_q <= '0;
    end else if (accept) begin
      op_q    <= req_op;
      addr_q  <= req_addr;
      src_q   <= req_src;
      cnt_q   <= req_len;
      wdata_q <= req_wdata;
    end else begin
      case (state)
        RD: begin
          if (op_q == OP_LOAD) rdata_q <= mem_Data_out;
          else                 buf_q   <= mem_Data_out;
        end
        WR: begin
          if (op_q == OP_FILL || op_q == OP_COPY) begin
            addr_q <= addr_q + AW'(1);
            src_q  <= src_q + AW'(1);
            if (cnt_q != '0) cnt_q <= cnt_q - AW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  // Memory pins depend only on state and captured registers.
  always_comb begin
    mem_E       = 1'b0;
    mem_WE      = 1'b0;
    mem_Addr    = '0;
    mem_Data_in = '0;
    case (state)
      RD: begin
        mem_E    = 1'b1;
        mem_Addr = (op_q == OP_COPY) ? src_q : addr_q;
      end
      WR: begin
        mem_E       = 1'b1;
        mem_WE      = 1'b1;
        mem_Addr    = addr_q;
        mem_Data_in = (op_q == OP_COPY) ? buf_q : wdata_q;
      end
      default: ;
    endcase
  end

  assign req_ready = (state == IDLE);
  assign busy      = (state != IDLE);
  assign done      = (state == DONE);
  assign rdata     = rdata_q;

endmodule

// File: tb/tb_data_mem_controller.sv
// Self-checking bench for data_mem_controller: bench-side memory, an
// operation-level reference model and per-cycle pin checks.
module tb_data_mem_controller;

  localparam int unsigned AW = 4;
  localparam int unsigned DW = 8;
  localparam int unsigned DEPTH = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          req_valid;
  logic          req_ready;
  logic [1:0]    req_op;
  logic [AW-1:0] req_addr;
  logic [AW-1:0] req_src;
  logic [AW-1:0] req_len;
  logic [DW-1:0] req_wdata;
  logic          busy;
  logic          done;
  logic [DW-1:0] rdata;
  logic          mem_E;
  logic          mem_WE;
  logic [AW-1:0] mem_Addr;
  logic [DW-1:0] mem_Data_in;
  logic [DW-1:0] mem_Data_out;

  data_mem_controller dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_addr(req_addr), .req_src(req_src), .req_len(req_len), .req_wdata(req_wdata),
    .busy(busy), .done(done), .rdata(rdata),
    .mem_E(mem_E), .mem_WE(mem_WE), .mem_Addr(mem_Addr),
    .mem_Data_in(mem_Data_in), .mem_Data_out(mem_Data_out)
  );

  always #5 clk = ~clk;

  logic [DW-1:0] mem [DEPTH];
  always @(posedge clk) if (mem_E && mem_WE) mem[mem_Addr] <= mem_Data_in;
  assign mem_Data_out = (mem_E && !mem_WE) ? mem[mem_Addr] : 8'h00;

  int done_cnt = 0;
  always @(negedge clk) if (done) done_cnt <= done_cnt + 1;

  typedef struct {
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } step_t;

  step_t         tr[$];
  logic [DW-1:0] ref_mem [DEPTH];
  logic [DW-1:0] exp_rdata;
  logic [DW-1:0] load_val;
  logic          is_load;
  int            checks = 0;
  int            errors = 0;
  int            n_done = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Expected pin trace of one request, derived from the op's meaning.
  task automatic build_trace(input logic [1:0] op, input logic [AW-1:0] addr,
                             input logic [AW-1:0] src, input logic [AW-1:0] len,
                             input logic [DW-1:0] wdata);
    logic [DW-1:0] tmp [DEPTH];
    int n;
    tmp = ref_mem;
    tr.delete();
    is_load = 1'b0;
    n = int'(len) + 1;
    case (op)
      2'b00: begin
        tr.push_back('{1'b0, addr, 8'h00});
        is_load = 1'b1;
        load_val = tmp[addr];
      end
      2'b01: tr.push_back('{1'b1, addr, wdata});
      2'b11: for (int i = 0; i < n; i++) tr.push_back('{1'b1, AW'(int'(addr) + i), wdata});
      default: for (int i = 0; i < n; i++) begin
        logic [AW-1:0] s, d;
        s = AW'(int'(src) + i);
        d = AW'(int'(addr) + i);
        tr.push_back('{1'b0, s, 8'h00});
        tr.push_back('{1'b1, d, tmp[s]});
        tmp[d] = tmp[s];
      end
    endcase
  endtask

  task automatic apply_trace(input int limit);
    for (int k = 0; k < limit; k++) if (tr[k].we) ref_mem[tr[k].addr] = tr[k].data;
  endtask

  // Called at a negedge with a request driven; returns at the negedge of cycle 1.
  task automatic accept_wait();
    logic ok;
    ok = 1'b0;
    for (int i = 0; i < 64; i++) begin
      if (req_ready) begin
        @(posedge clk);
        @(negedge clk);
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    check("accept_timeout", 32'(ok), 32'(1));
  endtask

  task automatic check_trace(input int rst_at);
    for (int k = 0; k < tr.size(); k++) begin
      if (k == rst_at) begin
        rst = 1'b1;
        #1;
        check("rst_mem_E", 32'(mem_E), 32'(0));
        check("rst_req_ready", 32'(req_ready), 32'(1));
        check("rst_busy", 32'(busy), 32'(0));
        check("rst_rdata", 32'(rdata), 32'(0));
        @(negedge clk);
        rst = 1'b0;
        for (int c = 0; c < 3; c++) begin
          check("rst_no_done", 32'(done), 32'(0));
          @(negedge clk);
        end
        apply_trace(rst_at);
        exp_rdata = '0;
        return;
      end
      check($sformatf("c%0d_mem_E", k + 1), 32'(mem_E), 32'(1));
      check($sformatf("c%0d_mem_WE", k + 1), 32'(mem_WE), 32'(tr[k].we));
      check($sformatf("c%0d_mem_Addr", k + 1), 32'(mem_Addr), 32'(tr[k].addr));
      if (tr[k].we) check($sformatf("c%0d_mem_Data_in", k + 1), 32'(mem_Data_in), 32'(tr[k].data));
      check($sformatf("c%0d_done", k + 1), 32'(done), 32'(0));
      check($sformatf("c%0d_req_ready", k + 1), 32'(req_ready), 32'(0));
      @(negedge clk);
    end
    if (is_load) exp_rdata = load_val;
    check("done_pulse", 32'(done), 32'(1));
    check("done_mem_E", 32'(mem_E), 32'(0));
    check("done_req_ready", 32'(req_ready), 32'(0));
    check("rdata", 32'(rdata), 32'(exp_rdata));
    @(negedge clk);
    check("idle_done", 32'(done), 32'(0));
    check("idle_req_ready", 32'(req_ready), 32'(1));
    check("idle_busy", 32'(busy), 32'(0));
    apply_trace(tr.size());
    n_done++;
  endtask

  task automatic drive(input logic [1:0] op, input logic [AW-1:0] addr, input logic [AW-1:0] src,
                       input logic [AW-1:0] len, input logic [DW-1:0] wdata);
    req_op = op; req_addr = addr; req_src = src; req_len = len; req_wdata = wdata;
    req_valid = 1'b1;
  endtask

  task automatic run_req(input logic [1:0] op, input logic [AW-1:0] addr, input logic [AW-1:0] src,
                         input logic [AW-1:0] len, input logic [DW-1:0] wdata, input int rst_at = -1);
    build_trace(op, addr, src, len, wdata);
    drive(op, addr, src, len, wdata);
    accept_wait();
    req_valid = 1'b0;
    check_trace(rst_at);
  endtask

  task automatic check_mem(input string tag);
    for (int i = 0; i < int'(DEPTH); i++)
      check($sformatf("%s_mem%0d", tag, i), 32'(mem[i]), 32'(ref_mem[i]));
  endtask

  initial begin
    rst = 1'b1; req_valid = 1'b0; req_op = '0; req_addr = '0; req_src = '0;
    req_len = '0; req_wdata = '0; exp_rdata = '0; load_val = '0; is_load = 1'b0;
    for (int i = 0; i < int'(DEPTH); i++) ref_mem[i] = '0;
    #2;
    check("reset_req_ready", 32'(req_ready), 32'(1));
    check("reset_busy", 32'(busy), 32'(0));
    check("reset_done", 32'(done), 32'(0));
    check("reset_rdata", 32'(rdata), 32'(0));
    check("reset_mem_pins", {mem_E, mem_WE, 2'b00, mem_Addr, mem_Data_in}, 32'(0));
    repeat (2) @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < int'(DEPTH); i++) run_req(2'b01, AW'(i), '0, '0, DW'($urandom));
    check_mem("init");

    run_req(2'b01, 4'd3, '0, '0, 8'hA5);
    run_req(2'b00, 4'd3, '0, '0, '0);
    check("load_a5", 32'(rdata), 32'h0000_00A5);

    run_req(2'b11, 4'd14, '0, 4'd3, 8'h5C);
    run_req(2'b00, 4'd14, '0, '0, '0);
    run_req(2'b00, 4'd1, '0, '0, '0);
    run_req(2'b00, 4'd2, '0, '0, '0);
    check_mem("fill_wrap");

    run_req(2'b01, 4'd4, '0, '0, 8'h11);
    run_req(2'b01, 4'd5, '0, '0, 8'h22);
    run_req(2'b10, 4'd8, 4'd4, 4'd1, '0);
    check("copy_mem8", 32'(mem[8]), 32'h0000_0011);
    check("copy_mem9", 32'(mem[9]), 32'h0000_0022);

    for (int i = 0; i < 4; i++) run_req(2'b01, AW'(i), '0, '0, DW'(8'h0A + i));
    run_req(2'b10, 4'd1, 4'd0, 4'd2, '0);
    check_mem("overlap");

    run_req(2'b11, 4'd0, '0, 4'd7, 8'hFF, 3);
    check_mem("rst_fill");

    // Second request held valid while a FILL is in progress.
    build_trace(2'b11, 4'd6, '0, 4'd3, 8'h3C);
    drive(2'b11, 4'd6, '0, 4'd3, 8'h3C);
    accept_wait();
    drive(2'b01, 4'd12, '0, '0, 8'h77);
    check_trace(-1);
    build_trace(2'b01, 4'd12, '0, '0, 8'h77);
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    check_trace(-1);
    check_mem("held");

    run_req(2'b11, 4'd9, '0, 4'd15, 8'h81);
    run_req(2'b10, 4'd5, 4'd2, 4'd15, '0);
    check_mem("len16");

    for (int i = 0; i < 40; i++)
      run_req(2'($urandom_range(0, 3)), AW'($urandom), AW'($urandom), AW'($urandom), DW'($urandom));
    check_mem("random");
    check("done_count", 32'(done_cnt), 32'(n_done));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
